mem_bus_arbiter: RTL and testbench

Shares the single 16x8 memory port between two requesters: requester 0 (fetch) and requester 1 (execute/load-store). It runs a round-robin arbiter and a small access FSM. The FSM drives mem_enable, read_write, address_bus and data_bus_in, and captures data_bus_out. Each requester sees a req/gnt/done handshake. It sits between the control unit and the memory block.

---
 rtl/mem_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// A four-state access FSM issues one access at a time and reports completion.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_enable,
  output logic              read_write,
  output logic [ADDR_W-1:0] address_bus,
  output logic [DATA_W-1:0] data_bus_in,
  input  logic [DATA_W-1:0] data_bus_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_t              state_reg, state_next;
  logic                owner_reg, owner_next;
  logic                last_reg, last_next;
  logic                rw_reg, rw_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [2:0]          cnt_reg, cnt_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;

  logic [1:0]          req_vec;
  logic [1:0]          rw_vec;
  logic [ADDR_W-1:0]   addr_vec  [2];
  logic [DATA_W-1:0]   wdata_vec [2];
  logic [1:0]          gnt_vec;
  logic [1:0]          done_vec;
  logic                sel;

  assign req_vec      = {req1, req0};
  assign rw_vec       = {rw1, rw0};
  assign addr_vec[0]  = addr0;
  assign addr_vec[1]  = addr1;
  assign wdata_vec[0] = wdata0;
  assign wdata_vec[1] = wdata1;

  // Grant spans ISSUE..DONE; done is only the DONE cycle of the owner.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign gnt_vec[gi]  = (state_reg != IDLE) && (owner_reg == 1'(gi));
      assign done_vec[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign gnt0  = gnt_vec[0];
  assign gnt1  = gnt_vec[1];
  assign done0 = done_vec[0];
  assign done1 = done_vec[1];

  // On contention pick the requester that was not served last.
  assign sel = (req_vec == 2'b11) ? ~last_reg : req_vec[1];

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    rw_next    = rw_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          owner_next = sel;
          rw_next    = rw_vec[sel];
          addr_next  = addr_vec[sel];
          wdata_next = wdata_vec[sel];
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (rw_reg) begin
          cnt_next   = LAT_INIT;
          state_next = WAIT;
        end else begin
          state_next = DONE;
        end
      end
      WAIT: begin
        if (cnt_reg <= 3'd1) begin
          rdata_next = data_bus_out;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      DONE: begin
        last_next  = owner_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      rw_reg    <= 1'b1;
      addr_reg  <= '0;
      wdata_reg <= '0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      rw_reg    <= rw_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
    end
  end

  // Memory port is parked (read, address 0) while idle.
  assign busy        = (state_reg != IDLE);
  assign mem_enable  = (state_reg == ISSUE);
  assign read_write  = (state_reg == IDLE) ? 1'b1 : rw_reg;
  assign address_bus = (state_reg == IDLE) ? '0 : addr_reg;
  assign data_bus_in = (state_reg == IDLE) ? '0 : wdata_reg;
  assign rdata       = rdata_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: default-latency instance plus a MEM_LAT=3
// instance, each attached to a small behavioural 16x8 memory.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  always #5 clk = ~clk;

  logic       req0 = 0, rw0 = 0, req1 = 0, rw1 = 0;
  logic [3:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic       gnt0, gnt1, done0, done1, busy, mem_enable, read_write;
  logic [7:0] rdata, data_bus_in, data_bus_out;
  logic [3:0] address_bus;

  logic       req0_b = 0, rw0_b = 0, req1_b = 0, rw1_b = 0;
  logic [3:0] addr0_b = 0, addr1_b = 0;
  logic [7:0] wdata0_b = 0, wdata1_b = 0;
  logic       gnt0_b, gnt1_b, done0_b, done1_b, busy_b, mem_enable_b, read_write_b;
  logic [7:0] rdata_b, data_bus_in_b, data_bus_out_b;
  logic [3:0] address_bus_b;

  mem_bus_arbiter #(.ADDR_W(4), .DATA_W(8), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy), .mem_enable(mem_enable), .read_write(read_write),
    .address_bus(address_bus), .data_bus_in(data_bus_in), .data_bus_out(data_bus_out)
  );

  mem_bus_arbiter #(.ADDR_W(4), .DATA_W(8), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset),
    .req0(req0_b), .rw0(rw0_b), .addr0(addr0_b), .wdata0(wdata0_b),
    .req1(req1_b), .rw1(rw1_b), .addr1(addr1_b), .wdata1(wdata1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
    .rdata(rdata_b), .busy(busy_b), .mem_enable(mem_enable_b), .read_write(read_write_b),
    .address_bus(address_bus_b), .data_bus_in(data_bus_in_b), .data_bus_out(data_bus_out_b)
  );

  // Memory A: 1-cycle read latency, data valid only in the cycle after the issue edge.
  logic [7:0] mem_a [16];
  logic [7:0] rd_a = 8'h00;
  always @(posedge clk) begin
    if (mem_enable && !read_write) mem_a[address_bus] <= data_bus_in;
    rd_a <= (mem_enable && read_write) ? mem_a[address_bus] : 8'h00;
  end
  assign data_bus_out = rd_a;

  // Memory B: read-only preloaded contents, 3-stage read pipeline.
  logic [7:0] mem_b [16];
  logic [7:0] pb1 = 8'h00, pb2 = 8'h00, pb3 = 8'h00;
  always @(posedge clk) begin
    pb1 <= (mem_enable_b && read_write_b) ? mem_b[address_bus_b] : 8'h00;
    pb2 <= pb1;
    pb3 <= pb2;
  end
  assign data_bus_out_b = pb3;

  wire [6:0] st_a = {gnt0, gnt1, done0, done1, busy, mem_enable, read_write};
  wire [6:0] st_b = {gnt0_b, gnt1_b, done0_b, done1_b, busy_b, mem_enable_b, read_write_b};

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (st_a !== 7'b0000001) begin n_fail++; $display("FAIL reset_status_a: got %b expected %b", st_a, 7'b0000001); end
    n_cmp++; if ({address_bus, data_bus_in, rdata} !== 20'h0) begin n_fail++; $display("FAIL reset_buses_a: got %h expected %h", {address_bus, data_bus_in, rdata}, 20'h0); end
    n_cmp++; if (st_b !== 7'b0000001) begin n_fail++; $display("FAIL reset_status_b: got %b expected %b", st_b, 7'b0000001); end
    n_cmp++; if ({address_bus_b, data_bus_in_b, rdata_b} !== 20'h0) begin n_fail++; $display("FAIL reset_buses_b: got %h expected %h", {address_bus_b, data_bus_in_b, rdata_b}, 20'h0); end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (st_a !== 7'b0000001) begin n_fail++; $display("FAIL idle_after_reset[%0d]: got %b expected %b", i, st_a, 7'b0000001); end
    end
    $display("reset: held 2 cycles, idle 5 cycles");
  endtask

  task automatic test_write();
    req0 = 1; rw0 = 0; addr0 = 4'd5; wdata0 = 8'h0F;
    tick();
    n_cmp++; if (st_a !== 7'b1000110) begin n_fail++; $display("FAIL wr_issue_status: got %b expected %b", st_a, 7'b1000110); end
    n_cmp++; if ({address_bus, data_bus_in} !== 12'h50F) begin n_fail++; $display("FAIL wr_issue_bus: got %h expected %h", {address_bus, data_bus_in}, 12'h50F); end
    tick();
    n_cmp++; if (st_a !== 7'b1010100) begin n_fail++; $display("FAIL wr_done_status: got %b expected %b", st_a, 7'b1010100); end
    req0 = 0;
    tick();
    n_cmp++; if (st_a !== 7'b0000001) begin n_fail++; $display("FAIL wr_idle_status: got %b expected %b", st_a, 7'b0000001); end
    n_cmp++; if (mem_a[5] !== 8'h0F) begin n_fail++; $display("FAIL wr_mem_content: got %h expected %h", mem_a[5], 8'h0F); end
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL wr_rdata_untouched: got %h expected %h", rdata, 8'h00); end
    $display("write: req0 addr 5 data 0F");
  endtask

  task automatic test_read();
    req1 = 1; rw1 = 1; addr1 = 4'd5; wdata1 = 8'h33;
    tick();
    n_cmp++; if (st_a !== 7'b0100111) begin n_fail++; $display("FAIL rd_issue_status: got %b expected %b", st_a, 7'b0100111); end
    n_cmp++; if (address_bus !== 4'd5) begin n_fail++; $display("FAIL rd_issue_addr: got %h expected %h", address_bus, 4'd5); end
    tick();
    n_cmp++; if (st_a !== 7'b0100101) begin n_fail++; $display("FAIL rd_wait_status: got %b expected %b", st_a, 7'b0100101); end
    n_cmp++; if (address_bus !== 4'd5) begin n_fail++; $display("FAIL rd_wait_addr: got %h expected %h", address_bus, 4'd5); end
    tick();
    n_cmp++; if (st_a !== 7'b0101101) begin n_fail++; $display("FAIL rd_done_status: got %b expected %b", st_a, 7'b0101101); end
    n_cmp++; if (rdata !== 8'h0F) begin n_fail++; $display("FAIL rd_done_rdata: got %h expected %h", rdata, 8'h0F); end
    req1 = 0;
    tick();
    n_cmp++; if (st_a !== 7'b0000001) begin n_fail++; $display("FAIL rd_idle_status: got %b expected %b", st_a, 7'b0000001); end
    n_cmp++; if (rdata !== 8'h0F) begin n_fail++; $display("FAIL rd_rdata_held: got %h expected %h", rdata, 8'h0F); end
    $display("read: req1 addr 5 -> %h", rdata);
  endtask

  task automatic test_reset_abort();
    req1 = 1; rw1 = 1; addr1 = 4'd5;
    tick();
    n_cmp++; if (st_a !== 7'b0100111) begin n_fail++; $display("FAIL abort_issue_status: got %b expected %b", st_a, 7'b0100111); end
    tick();
    n_cmp++; if (st_a !== 7'b0100101) begin n_fail++; $display("FAIL abort_wait_status: got %b expected %b", st_a, 7'b0100101); end
    reset = 1; req1 = 0;
    tick();
    n_cmp++; if (st_a !== 7'b0000001) begin n_fail++; $display("FAIL abort_status: got %b expected %b", st_a, 7'b0000001); end
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL abort_rdata: got %h expected %h", rdata, 8'h00); end
    reset = 0;
    tick();
    n_cmp++; if (st_a !== 7'b0000001) begin n_fail++; $display("FAIL abort_no_done: got %b expected %b", st_a, 7'b0000001); end
    $display("abort: reset during read wait on req1");
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_st;
    logic [11:0] exp_bus;
    reset = 1;
    tick();
    tick();
    reset = 0;
    req0 = 1; rw0 = 0; addr0 = 4'd1; wdata0 = 8'h11;
    req1 = 1; rw1 = 0; addr1 = 4'd2; wdata1 = 8'h22;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_st  = (k % 2 == 1) ? 7'b0100110 : 7'b1000110;
      exp_bus = (k % 2 == 1) ? 12'h222 : 12'h111;
      n_cmp++; if (st_a !== exp_st) begin n_fail++; $display("FAIL b2b_issue[%0d]: got %b expected %b", k, st_a, exp_st); end
      n_cmp++; if ({address_bus, data_bus_in} !== exp_bus) begin n_fail++; $display("FAIL b2b_bus[%0d]: got %h expected %h", k, {address_bus, data_bus_in}, exp_bus); end
      tick();
      exp_st = (k % 2 == 1) ? 7'b0101100 : 7'b1010100;
      n_cmp++; if (st_a !== exp_st) begin n_fail++; $display("FAIL b2b_done[%0d]: got %b expected %b", k, st_a, exp_st); end
      tick();
      n_cmp++; if (st_a !== 7'b0000001) begin n_fail++; $display("FAIL b2b_idle[%0d]: got %b expected %b", k, st_a, 7'b0000001); end
      $display("back_to_back: grant %0d to requester %0d", k, k % 2);
    end
    req0 = 0; req1 = 0;
    tick();
    n_cmp++; if (st_a !== 7'b0000001) begin n_fail++; $display("FAIL b2b_quiet: got %b expected %b", st_a, 7'b0000001); end
    n_cmp++; if ({mem_a[1], mem_a[2]} !== 16'h1122) begin n_fail++; $display("FAIL b2b_mem: got %h expected %h", {mem_a[1], mem_a[2]}, 16'h1122); end
  endtask

  task automatic test_long_latency();
    req0_b = 1; rw0_b = 1; addr0_b = 4'd2; wdata0_b = 8'h5A;
    tick();
    n_cmp++; if (st_b !== 7'b1000111) begin n_fail++; $display("FAIL lat_issue_status: got %b expected %b", st_b, 7'b1000111); end
    n_cmp++; if (address_bus_b !== 4'd2) begin n_fail++; $display("FAIL lat_issue_addr: got %h expected %h", address_bus_b, 4'd2); end
    req0_b = 0; rw0_b = 0; addr0_b = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (st_b !== 7'b1000101) begin n_fail++; $display("FAIL lat_wait[%0d]: got %b expected %b", i, st_b, 7'b1000101); end
      n_cmp++; if (address_bus_b !== 4'd2) begin n_fail++; $display("FAIL lat_wait_addr[%0d]: got %h expected %h", i, address_bus_b, 4'd2); end
    end
    tick();
    n_cmp++; if (st_b !== 7'b1010101) begin n_fail++; $display("FAIL lat_done_status: got %b expected %b", st_b, 7'b1010101); end
    n_cmp++; if (rdata_b !== 8'hA5) begin n_fail++; $display("FAIL lat_done_rdata: got %h expected %h", rdata_b, 8'hA5); end
    tick();
    n_cmp++; if (st_b !== 7'b0000001) begin n_fail++; $display("FAIL lat_idle_status: got %b expected %b", st_b, 7'b0000001); end
    $display("long_latency: req0 read addr 2 -> %h", rdata_b);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_b[i] = 8'(i * 17);
    mem_b[2] = 8'hA5;
    test_reset();
    test_write();
    test_read();
    test_reset_abort();
    test_back_to_back();
    test_long_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
